// File: rtl/prescaled_binary_counter.sv
// Prescaled WIDTH-bit up/down counter: a DIV-cycle prescaler emits a one-cycle tick that advances Q.
// Optional build macro PRESCALED_COUNTER_SATURATE_EN makes Q saturate at its end values instead of wrapping.
module prescaled_binary_counter #(
    parameter int          WIDTH = 4,
    parameter int unsigned DIV   = 134000000,
    parameter int          DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             tick,
    output logic             tc
);

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [WIDTH-1:0] q_q, q_d, q_step;
    logic             tick_q, tick_d;
    logic             rollover;

    // Reset deassertion is expected to arrive already aligned to clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            q_q     <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            q_q     <= q_d;
            tick_q  <= tick_d;
        end
    end

    assign tc       = up_down ? (q_q == {WIDTH{1'b1}}) : (q_q == '0);
    assign rollover = enable && (presc_q == DIV_W'(DIV - 1));
    assign q_step   = up_down ? q_q + WIDTH'(1) : q_q - WIDTH'(1);

    always_comb begin
        presc_d = presc_q;
        q_d     = q_q;
        tick_d  = 1'b0;
        // Load outranks a coincident rollover and restarts the prescaler phase.
        if (load) begin
            q_d     = load_value;
            presc_d = '0;
        end else if (rollover) begin
            presc_d = '0;
            tick_d  = 1'b1;
`ifdef PRESCALED_COUNTER_SATURATE_EN
            if (!tc) q_d = q_step;
`else
            q_d = q_step;
`endif
        end else if (enable) begin
            presc_d = presc_q + DIV_W'(1);
        end
    end

    assign Q    = q_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_prescaled_binary_counter.sv
// Scoreboard bench for prescaled_binary_counter (WIDTH=4, DIV=4): expected ticks are queued, a monitor checks them.
module tb_prescaled_binary_counter;

    logic       clk = 1'b0;
    logic       reset, enable, up_down, load;
    logic [3:0] load_value;
    logic [3:0] Q;
    logic       tick, tc;

    typedef struct {
        int         cyc;
        logic [3:0] q;
        logic       tc;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    prescaled_binary_counter #(.WIDTH(4), .DIV(4), .DIV_W(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .Q(Q), .tick(tick), .tc(tc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n rising edges, then settle just past the following falling edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Monitor: every tick must match the head of the scoreboard, on the expected cycle.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (tick) begin
                if (sbq.size() == 0) begin
                    chk("tick_unexpected", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("tick_cyc", cyc, e.cyc);
                    chk("tick_Q", int'(Q), int'(e.q));
                    chk("tick_tc", int'(tc), int'(e.tc));
                end
            end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                chk("tick_missed", cyc, sbq[0].cyc);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b0; enable = 1'b1; up_down = 1'b1; load = 1'b0; load_value = 4'h0;

        // Reset held for three clocks
        repeat (3) begin
            cycles(1);
            chk("rst_Q", int'(Q), 0);
            chk("rst_tick", int'(tick), 0);
            chk("rst_tc", int'(tc), 0);
        end
        reset = 1'b1;

        // Free count up: ticks every 4 cycles, tc at 15, wrap to 0 after 64 cycles
        for (int k = 1; k <= 16; k++)
            sbq.push_back('{cyc + 4 * k, 4'(k), (k == 15)});
        cycles(64);

        // Down count from 0
        up_down = 1'b0;
        #1;
        chk("down_tc_at0", int'(tc), 1);
`ifdef PRESCALED_COUNTER_SATURATE_EN
        sbq.push_back('{cyc + 4, 4'h0, 1'b1});
        sbq.push_back('{cyc + 8, 4'h0, 1'b1});
`else
        sbq.push_back('{cyc + 4, 4'hF, 1'b0});
        sbq.push_back('{cyc + 8, 4'hE, 1'b0});
`endif
        cycles(8);

        // Load coincident with prescaler at DIV-1: no tick, prescaler restarts
        cycles(3);
        up_down = 1'b1; load = 1'b1; load_value = 4'hA;
        cycles(1);
        load = 1'b0;
        chk("load_Q", int'(Q), 10);
        chk("load_no_tick", int'(tick), 0);
        sbq.push_back('{cyc + 4, 4'hB, 1'b0});
        cycles(4);

        // Enable freeze with prescaler at 2
        cycles(2);
        enable = 1'b0;
        repeat (10) begin
            cycles(1);
            chk("frz_Q", int'(Q), 11);
            chk("frz_tick", int'(tick), 0);
        end
        enable = 1'b1;
        sbq.push_back('{cyc + 2, 4'hC, 1'b0});
        cycles(2);

        // Async reset between edges with Q=7, prescaler=3
        load = 1'b1; load_value = 4'h7;
        cycles(1);
        load = 1'b0;
        chk("pre_arst_Q", int'(Q), 7);
        cycles(3);
        reset = 1'b0;
        #1;
        chk("arst_Q", int'(Q), 0);
        chk("arst_tick", int'(tick), 0);
        cycles(1);
        reset = 1'b1;
        sbq.push_back('{cyc + 4, 4'h1, 1'b0});
        cycles(4);

        // Direction flip at Q=15
        load = 1'b1; load_value = 4'hF;
        cycles(1);
        load = 1'b0;
        chk("flip_Q", int'(Q), 15);
        chk("flip_tc_up", int'(tc), 1);
        up_down = 1'b0;
        #1;
        chk("flip_tc_down", int'(tc), 0);
        sbq.push_back('{cyc + 4, 4'hE, 1'b0});
        cycles(4);

        cycles(2);
        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
